// File: rtl/pcie_ingress_ctrl.sv
// Ingress controller: host valid/ready words -> skid FIFO -> registered push/data to the main FIFO.
// Optional per-VC push counters are built when PCIE_INGRESS_STATS_EN is defined.
module pcie_ingress_ctrl #(
   parameter int DEPTH       = 4,
   parameter int INIT_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [5:0]       in_data,
   output logic             in_ready,
   input  logic             Pausa_MF,
   output logic             init_out,
   output logic             push_out,
   output logic [5:0]       data_out,
   output logic             busy_out,
   output logic [CNT_W-1:0] cnt_vc0,
   output logic [CNT_W-1:0] cnt_vc1
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

   typedef enum logic [1:0] {INIT, RUN, PAUSE} state_t;

   state_t          state_q;
   logic [7:0]      init_cnt_q;
   logic [5:0]      mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            init_q, push_q;
   logic [5:0]      data_q;
   logic            active, accept, pop;
   logic [5:0]      head;

   assign active   = (state_q == RUN) || (state_q == PAUSE);
   assign in_ready = active && (count_q < CW'(DEPTH));
   assign accept   = in_valid && in_ready;
   // An empty FIFO forwards the incoming word directly so it is pushed one cycle after acceptance.
   assign pop      = active && !Pausa_MF && ((count_q != '0) || accept);
   assign head     = (count_q == '0) ? in_data : mem_q[rptr_q];
   assign count_d  = count_q + CW'(accept) - CW'(pop);

   always_ff @(posedge clk) begin
      if (accept) mem_q[wptr_q] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         init_q     <= 1'b1;
         push_q     <= 1'b0;
         data_q     <= '0;
      end else begin
         case (state_q)
            INIT: begin
               if (init_cnt_q == INIT_LAST) begin
                  state_q <= RUN;
                  init_q  <= 1'b0;
               end else begin
                  init_cnt_q <= init_cnt_q + 8'd1;
               end
            end
            RUN:     if (Pausa_MF)  state_q <= PAUSE;
            PAUSE:   if (!Pausa_MF) state_q <= RUN;
            default: state_q <= INIT;
         endcase
         if (accept) wptr_q <= wptr_q + AW'(1);
         if (pop)    rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
         push_q  <= pop;
         if (pop) data_q <= head;
      end
   end

   assign init_out = init_q;
   assign push_out = push_q;
   assign data_out = data_q;
   assign busy_out = (count_q != '0) | push_q;

`ifdef PCIE_INGRESS_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   // Counts follow the registered push, so they trail push_out by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (push_q) begin
         if (!data_q[5] && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
         if (data_q[5]  && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
      end
   end

   assign cnt_vc0 = cnt0_q;
   assign cnt_vc1 = cnt1_q;
`else
   assign cnt_vc0 = '0;
   assign cnt_vc1 = '0;
`endif

endmodule
